// File: rtl/axi_aw_arbiter_push_pkg.sv
// Shared types and constants for the AXI node write-address path.
// Holds the AW payload layout, the arbiter state encoding and width helpers.
package axi_node_pkg;

    localparam int DEF_N_TARG_PORT = 7;
    localparam int DEF_AXI_ADDR_W  = 32;
    localparam int DEF_AXI_ID_IN   = 4;
    localparam int DEF_AXI_USER_W  = 6;
    localparam int AXI_LEN_W       = 8;
    localparam int AXI_SIZE_W      = 3;
    localparam int AXI_BURST_W     = 2;

    typedef enum logic {
        ARB  = 1'b0,
        HOLD = 1'b1
    } aw_state_t;

    // Index width that never collapses to zero bits, so a single port still has an index.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // AW payload in the node's default geometry (incoming ID width).
    typedef struct packed {
        logic [DEF_AXI_ID_IN-1:0]  id;
        logic [DEF_AXI_ADDR_W-1:0] addr;
        logic [AXI_LEN_W-1:0]      len;
        logic [AXI_SIZE_W-1:0]     size;
        logic [AXI_BURST_W-1:0]    burst;
        logic [DEF_AXI_USER_W-1:0] user;
    } aw_payload_t;

endpackage

// File: rtl/axi_aw_rr_pick.sv
// Combinational rotating-priority picker: first requester at or after ptr,
// wrapping modulo N, reported as one-hot grant, binary index and any-flag.
module axi_aw_rr_pick
    import axi_node_pkg::*;
#(
    parameter int N     = DEF_N_TARG_PORT,
    parameter int IDX_W = idx_w(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] bin,
    output logic             any
);

    logic [IDX_W-1:0] cand [N];

    // cand[k] is the port index examined at priority rank k.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_cand
            logic [IDX_W:0] sum;
            assign sum = {1'b0, ptr} + (IDX_W+1)'(gi);
            assign cand[gi] = (sum >= (IDX_W+1)'(N)) ? IDX_W'(sum - (IDX_W+1)'(N))
                                                     : sum[IDX_W-1:0];
        end
    endgenerate

    always_comb begin
        bin = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[cand[k]]) begin
                bin = cand[k];
            end
        end
        any = |req;
    end

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_grant
            assign grant[gi] = any & (bin == IDX_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/axi_aw_arbiter_push.sv
// Round-robin AW arbiter for one initiator port; pushes {BIN_ID, OH_ID} to the
// write-data allocator's ID FIFO per AW handshake. Optional AW_OUT_REG_EN adds an output slice.
module axi_aw_arbiter_push
    import axi_node_pkg::*;
#(
    parameter int N_TARG_PORT = DEF_N_TARG_PORT,
    parameter int LOG_N_TARG  = idx_w(N_TARG_PORT),
    parameter int AXI_ADDR_W  = DEF_AXI_ADDR_W,
    parameter int AXI_ID_IN   = DEF_AXI_ID_IN,
    parameter int AXI_USER_W  = DEF_AXI_USER_W,
    parameter int AXI_ID_OUT  = AXI_ID_IN + LOG_N_TARG
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [N_TARG_PORT-1:0][AXI_ID_IN-1:0]  awid_i,
    input  logic [N_TARG_PORT-1:0][AXI_ADDR_W-1:0] awaddr_i,
    input  logic [N_TARG_PORT-1:0][7:0]            awlen_i,
    input  logic [N_TARG_PORT-1:0][2:0]            awsize_i,
    input  logic [N_TARG_PORT-1:0][1:0]            awburst_i,
    input  logic [N_TARG_PORT-1:0][AXI_USER_W-1:0] awuser_i,
    input  logic [N_TARG_PORT-1:0]                 awvalid_i,
    output logic [N_TARG_PORT-1:0]                 awready_o,
    output logic [AXI_ID_OUT-1:0]                  awid_o,
    output logic [AXI_ADDR_W-1:0]                  awaddr_o,
    output logic [7:0]                             awlen_o,
    output logic [2:0]                             awsize_o,
    output logic [1:0]                             awburst_o,
    output logic [AXI_USER_W-1:0]                  awuser_o,
    output logic                                   awvalid_o,
    input  logic                                   awready_i,
    output logic                                   push_ID_o,
    output logic [LOG_N_TARG+N_TARG_PORT-1:0]      ID_o,
    input  logic                                   grant_FIFO_ID_i
);

    typedef struct packed {
        logic [AXI_ID_OUT-1:0] id;
        logic [AXI_ADDR_W-1:0] addr;
        logic [7:0]            len;
        logic [2:0]            size;
        logic [1:0]            burst;
        logic [AXI_USER_W-1:0] user;
    } aw_pld_t;

    aw_state_t              state_reg, state_next;
    logic [LOG_N_TARG-1:0]  rr_ptr_reg, rr_ptr_next;
    logic [LOG_N_TARG-1:0]  lock_idx_reg, lock_idx_next;

    logic [N_TARG_PORT-1:0] eligible;
    logic [N_TARG_PORT-1:0] pick_oh;
    logic [LOG_N_TARG-1:0]  pick_bin;
    logic                   pick_any;

    logic [LOG_N_TARG-1:0]  sel_idx;
    logic [N_TARG_PORT-1:0] sel_oh;
    logic [LOG_N_TARG-1:0]  sel_idx_inc;
    logic                   arb_valid;
    logic                   arb_ready;
    logic                   arb_hs;
    aw_pld_t                sel_pld;
    aw_pld_t                out_pld;
    logic                   out_valid;

    // Nothing is eligible while the ID FIFO cannot take the routing word.
    assign eligible = awvalid_i & {N_TARG_PORT{grant_FIFO_ID_i}};

    axi_aw_rr_pick #(
        .N     (N_TARG_PORT),
        .IDX_W (LOG_N_TARG)
    ) u_pick (
        .req   (eligible),
        .ptr   (rr_ptr_reg),
        .grant (pick_oh),
        .bin   (pick_bin),
        .any   (pick_any)
    );

    assign sel_idx     = (state_reg == HOLD) ? lock_idx_reg : pick_bin;
    assign sel_idx_inc = (sel_idx == LOG_N_TARG'(N_TARG_PORT - 1)) ? '0
                                                                   : sel_idx + LOG_N_TARG'(1);

    generate
        for (genvar gi = 0; gi < N_TARG_PORT; gi++) begin : g_sel_oh
            assign sel_oh[gi] = (sel_idx == LOG_N_TARG'(gi));
        end
    endgenerate

    // Outputs are forced low while reset is held, independent of the clock.
    assign arb_valid = rst_n & ((state_reg == HOLD) | pick_any);
    assign arb_hs    = arb_valid & arb_ready;

    always_comb begin
        sel_pld = '0;
        if (arb_valid) begin
            sel_pld.id    = {sel_idx, awid_i[sel_idx]};
            sel_pld.addr  = awaddr_i[sel_idx];
            sel_pld.len   = awlen_i[sel_idx];
            sel_pld.size  = awsize_i[sel_idx];
            sel_pld.burst = awburst_i[sel_idx];
            sel_pld.user  = awuser_i[sel_idx];
        end
    end

    always_comb begin
        state_next    = state_reg;
        rr_ptr_next   = rr_ptr_reg;
        lock_idx_next = lock_idx_reg;
        unique case (state_reg)
            ARB: begin
                if (arb_hs) begin
                    rr_ptr_next = sel_idx_inc;
                end else if (arb_valid) begin
                    state_next    = HOLD;
                    lock_idx_next = pick_bin;
                end
            end
            HOLD: begin
                if (arb_hs) begin
                    state_next  = ARB;
                    rr_ptr_next = sel_idx_inc;
                end
            end
            default: state_next = ARB;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ARB;
            rr_ptr_reg   <= '0;
            lock_idx_reg <= '0;
        end else begin
            state_reg    <= state_next;
            rr_ptr_reg   <= rr_ptr_next;
            lock_idx_reg <= lock_idx_next;
        end
    end

    assign awready_o = arb_hs ? sel_oh : '0;
    assign push_ID_o = arb_hs;
    assign ID_o      = arb_hs ? {sel_idx, sel_oh} : '0;

`ifdef AW_OUT_REG_EN
    // Two-entry FIFO slice: ready depends only on occupancy, sustaining one AW per cycle.
    aw_pld_t    slot_reg [2];
    logic [1:0] cnt_reg;
    logic       wr_sel_reg;
    logic       rd_sel_reg;
    logic       pop;

    assign arb_ready = (cnt_reg != 2'd2);
    assign out_valid = (cnt_reg != 2'd0);
    assign pop       = out_valid & awready_i;
    assign out_pld   = out_valid ? slot_reg[rd_sel_reg] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg     <= '0;
            wr_sel_reg  <= 1'b0;
            rd_sel_reg  <= 1'b0;
            slot_reg[0] <= '0;
            slot_reg[1] <= '0;
        end else begin
            if (arb_hs) begin
                slot_reg[wr_sel_reg] <= sel_pld;
                wr_sel_reg           <= ~wr_sel_reg;
            end
            if (pop) begin
                rd_sel_reg <= ~rd_sel_reg;
            end
            cnt_reg <= cnt_reg + 2'(arb_hs) - 2'(pop);
        end
    end
`else
    assign arb_ready = awready_i;
    assign out_valid = arb_valid;
    assign out_pld   = sel_pld;
`endif

    assign awvalid_o = out_valid;
    assign awid_o    = out_pld.id;
    assign awaddr_o  = out_pld.addr;
    assign awlen_o   = out_pld.len;
    assign awsize_o  = out_pld.size;
    assign awburst_o = out_pld.burst;
    assign awuser_o  = out_pld.user;

    // The ID FIFO cannot fill behind us while a request is locked.
    hold_fifo_grant: assert property (@(posedge clk) disable iff (!rst_n)
        (state_reg == HOLD) |-> grant_FIFO_ID_i);

    hold_req_kept: assert property (@(posedge clk) disable iff (!rst_n)
        (state_reg == HOLD) |-> awvalid_i[lock_idx_reg]);

    ready_with_push: assert property (@(posedge clk) disable iff (!rst_n)
        (|awready_o) |-> push_ID_o);

endmodule

// File: tb/tb_axi_aw_arbiter_push.sv
// Directed bench for axi_aw_arbiter_push (default build; AW_OUT_REG_EN selects the slice sequence).
module tb_axi_aw_arbiter_push;

    localparam int N  = 7;
    localparam int LG = 3;
    localparam int AW = 32;
    localparam int IW = 4;
    localparam int UW = 6;
    localparam int OW = IW + LG;

    logic                    clk;
    logic                    rst_n;
    logic [N-1:0][IW-1:0]    awid_i;
    logic [N-1:0][AW-1:0]    awaddr_i;
    logic [N-1:0][7:0]       awlen_i;
    logic [N-1:0][2:0]       awsize_i;
    logic [N-1:0][1:0]       awburst_i;
    logic [N-1:0][UW-1:0]    awuser_i;
    logic [N-1:0]            awvalid_i;
    logic [N-1:0]            awready_o;
    logic [OW-1:0]           awid_o;
    logic [AW-1:0]           awaddr_o;
    logic [7:0]              awlen_o;
    logic [2:0]              awsize_o;
    logic [1:0]              awburst_o;
    logic [UW-1:0]           awuser_o;
    logic                    awvalid_o;
    logic                    awready_i;
    logic                    push_ID_o;
    logic [LG+N-1:0]         ID_o;
    logic                    grant_FIFO_ID_i;

    int total = 0;
    int bad   = 0;

    axi_aw_arbiter_push dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .awid_i          (awid_i),
        .awaddr_i        (awaddr_i),
        .awlen_i         (awlen_i),
        .awsize_i        (awsize_i),
        .awburst_i       (awburst_i),
        .awuser_i        (awuser_i),
        .awvalid_i       (awvalid_i),
        .awready_o       (awready_o),
        .awid_o          (awid_o),
        .awaddr_o        (awaddr_o),
        .awlen_o         (awlen_o),
        .awsize_o        (awsize_o),
        .awburst_o       (awburst_o),
        .awuser_o        (awuser_o),
        .awvalid_o       (awvalid_o),
        .awready_i       (awready_i),
        .push_ID_o       (push_ID_o),
        .ID_o            (ID_o),
        .grant_FIFO_ID_i (grant_FIFO_ID_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [IW-1:0] pid(input int p);
        logic [IW-1:0] t;
        t = IW'(p);
        return t ^ 4'hA;
    endfunction

    function automatic logic [OW-1:0] exp_awid(input int p);
        return {LG'(p), pid(p)};
    endfunction

    function automatic logic [AW-1:0] paddr(input int p);
        return 32'h1000_0000 + 32'(p) * 32'h100;
    endfunction

    function automatic logic [LG+N-1:0] exp_id(input int p);
        logic [N-1:0] oh;
        oh = N'(1) << p;
        return {LG'(p), oh};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int pushes;

    initial begin
        rst_n           = 1'b0;
        awvalid_i       = '0;
        awready_i       = 1'b1;
        grant_FIFO_ID_i = 1'b1;
        for (int p = 0; p < N; p++) begin
            awid_i[p]    = pid(p);
            awaddr_i[p]  = paddr(p);
            awlen_i[p]   = 8'(p * 3 + 1);
            awsize_i[p]  = 3'(p);
            awburst_i[p] = 2'(p % 3);
            awuser_i[p]  = 6'(p + 16);
        end
        awvalid_i[0] = 1'b1;

        // Reset: outputs held low even with a live request.
        @(negedge clk);
        chk("rst_awvalid", 64'(awvalid_o), 64'd0);
        chk("rst_awready", 64'(awready_o), 64'd0);
        chk("rst_push", 64'(push_ID_o), 64'd0);
        chk("rst_ID", 64'(ID_o), 64'd0);
        chk("rst_awaddr", 64'(awaddr_o), 64'd0);
        $display("reset: awvalid_o=%0b push=%0b", awvalid_o, push_ID_o);
        tick();
        rst_n = 1'b1;
        awvalid_i = '0;

`ifdef AW_OUT_REG_EN
        // Back-to-back through the slice: AW out lags the push by one cycle.
        awvalid_i = '1;
        awready_i = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("slc_push", 64'(push_ID_o), 64'd1);
            chk("slc_ID", 64'(ID_o), 64'(exp_id(k % N)));
            chk("slc_awvalid", 64'(awvalid_o), (k > 0) ? 64'd1 : 64'd0);
            if (k > 0) begin
                chk("slc_awid", 64'(awid_o), 64'(exp_awid((k - 1) % N)));
            end
            $display("slice cycle %0d: push ID=0x%0h awvalid_o=%0b awid_o=0x%0h", k, ID_o, awvalid_o, awid_o);
            tick();
        end
        awvalid_i = '0;
`else
        // Ports 2 and 5, rr_ptr=0.
        awvalid_i[2] = 1'b1;
        awvalid_i[5] = 1'b1;
        @(negedge clk);
        chk("a0_awvalid", 64'(awvalid_o), 64'd1);
        chk("a0_awready", 64'(awready_o), 64'(7'b0000100));
        chk("a0_push", 64'(push_ID_o), 64'd1);
        chk("a0_ID", 64'(ID_o), 64'({3'd2, 7'b0000100}));
        chk("a0_awid", 64'(awid_o), 64'({3'd2, 4'h8}));
        chk("a0_awaddr", 64'(awaddr_o), 64'h1000_0200);
        chk("a0_awlen", 64'(awlen_o), 64'd7);
        $display("A: grant port2 ID=0x%0h awid_o=0x%0h", ID_o, awid_o);
        tick();
        awvalid_i[2] = 1'b0;
        @(negedge clk);
        chk("a1_awready", 64'(awready_o), 64'(7'b0100000));
        chk("a1_ID", 64'(ID_o), 64'({3'd5, 7'b0100000}));
        chk("a1_awuser", 64'(awuser_o), 64'd21);
        $display("A: grant port5 ID=0x%0h awid_o=0x%0h", ID_o, awid_o);
        tick();
        awvalid_i = '0;

        // Fresh reset, then all seven ports continuously.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        awvalid_i = '1;
        pushes = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k < N && push_ID_o) pushes++;
            chk("b_awready", 64'(awready_o), 64'(N'(1) << (k % N)));
            chk("b_ID", 64'(ID_o), 64'(exp_id(k % N)));
            $display("B cycle %0d: awready_o=0x%0h ID=0x%0h", k, awready_o, ID_o);
            tick();
        end
        chk("b_pushes", 64'(pushes), 64'd7);
        awvalid_i = '0;

        // rr_ptr=1: port 3 held four cycles, port 1 joins on the third.
        awvalid_i[3] = 1'b1;
        awready_i    = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k == 2) awvalid_i[1] = 1'b1;
            @(negedge clk);
            chk("c_hold_awvalid", 64'(awvalid_o), 64'd1);
            chk("c_hold_awid", 64'(awid_o), 64'({3'd3, 4'h9}));
            chk("c_hold_awaddr", 64'(awaddr_o), 64'h1000_0300);
            chk("c_hold_push", 64'(push_ID_o), 64'd0);
            chk("c_hold_awready", 64'(awready_o), 64'd0);
            $display("C hold %0d: awid_o=0x%0h push=%0b", k, awid_o, push_ID_o);
            tick();
        end
        awready_i = 1'b1;
        @(negedge clk);
        chk("c_acc_awready", 64'(awready_o), 64'(7'b0001000));
        chk("c_acc_ID", 64'(ID_o), 64'({3'd3, 7'b0001000}));
        $display("C accept: ID=0x%0h", ID_o);
        tick();
        awvalid_i[3] = 1'b0;
        @(negedge clk);
        chk("c_next_awready", 64'(awready_o), 64'(7'b0000010));
        chk("c_next_ID", 64'(ID_o), 64'({3'd1, 7'b0000010}));
        $display("C next: ID=0x%0h", ID_o);
        tick();
        awvalid_i = '0;

        // ID FIFO full blocks everything; grant return allows same-cycle handshake.
        grant_FIFO_ID_i = 1'b0;
        awvalid_i[0]    = 1'b1;
        @(negedge clk);
        chk("d_full_awvalid", 64'(awvalid_o), 64'd0);
        chk("d_full_push", 64'(push_ID_o), 64'd0);
        chk("d_full_awready", 64'(awready_o), 64'd0);
        $display("D full: awvalid_o=%0b push=%0b", awvalid_o, push_ID_o);
        tick();
        grant_FIFO_ID_i = 1'b1;
        @(negedge clk);
        chk("d_ok_awvalid", 64'(awvalid_o), 64'd1);
        chk("d_ok_awready", 64'(awready_o), 64'(7'b0000001));
        chk("d_ok_ID", 64'(ID_o), 64'({3'd0, 7'b0000001}));
        $display("D grant back: ID=0x%0h", ID_o);
        tick();
        awvalid_i = '0;

        // Reset while port 4 is locked in HOLD.
        awvalid_i[4] = 1'b1;
        awready_i    = 1'b0;
        @(negedge clk);
        chk("e_pre_awid", 64'(awid_o), 64'({3'd4, 4'hE}));
        tick();
        rst_n = 1'b0;
        #1;
        chk("e_rst_awvalid", 64'(awvalid_o), 64'd0);
        chk("e_rst_push", 64'(push_ID_o), 64'd0);
        chk("e_rst_awready", 64'(awready_o), 64'd0);
        $display("E reset in HOLD: awvalid_o=%0b push=%0b", awvalid_o, push_ID_o);
        tick();
        rst_n        = 1'b1;
        awready_i    = 1'b1;
        awvalid_i[0] = 1'b1;
        @(negedge clk);
        chk("e_post_awready", 64'(awready_o), 64'(7'b0000001));
        chk("e_post_ID", 64'(ID_o), 64'({3'd0, 7'b0000001}));
        $display("E after reset: ID=0x%0h", ID_o);
        tick();
        awvalid_i = '0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi_aw_arbiter_push.md
Name: axi_aw_arbiter_push

Overview:
- Write-address (AW) arbiter for one initiator (master) port of the AXI node.
- Round-robin selection of one AW request among N_TARG_PORT target (slave) ports; forwards it downstream with the winner's port index prepended to AWID.
- On every AW handshake, pushes routing word {BIN_ID, OH_ID} into the downstream write-data allocator's ID FIFO, so W beats are later steered in AW order.
- Sits directly upstream of the write-data allocator on the same initiator port.

Parameters:
- N_TARG_PORT, 7, number of target ports competing.
- LOG_N_TARG, $clog2(N_TARG_PORT), width of binary port index.
- AXI_ADDR_W, 32, address width.
- AXI_ID_IN, 4, incoming AWID width.
- AXI_USER_W, 6, AWUSER width.
- AXI_ID_OUT, AXI_ID_IN+LOG_N_TARG, outgoing AWID width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- awid_i  in  [N_TARG_PORT][AXI_ID_IN]  per-port AWID.
- awaddr_i  in  [N_TARG_PORT][AXI_ADDR_W]  per-port address.
- awlen_i  in  [N_TARG_PORT][8]  burst length.
- awsize_i  in  [N_TARG_PORT][3]  beat size.
- awburst_i  in  [N_TARG_PORT][2]  burst type.
- awuser_i  in  [N_TARG_PORT][AXI_USER_W]  user sideband.
- awvalid_i  in  [N_TARG_PORT]  request valid.
- awready_o  out  [N_TARG_PORT]  one-hot accept.
- awid_o  out  AXI_ID_OUT  {winner_bin, awid}.
- awaddr_o, awlen_o, awsize_o, awburst_o, awuser_o  out  matching widths  winner payload.
- awvalid_o  out  1  downstream valid.
- awready_i  in  1  downstream ready.
- push_ID_o  out  1  ID FIFO push strobe.
- ID_o  out  LOG_N_TARG+N_TARG_PORT  {BIN_ID, OH_ID} of winner.
- grant_FIFO_ID_i  in  1  ID FIFO not full.

Behaviour:
- Reset: rst_n, asynchronous, active-low; clock clk. On reset: state ARB, rr_ptr=0, all outputs 0.
- Eligible requests: awvalid_i gated by grant_FIFO_ID_i. No output valid while the FIFO is full.
- Pick: first eligible port scanning rr_ptr, rr_ptr+1, …, wrapping modulo N_TARG_PORT.
- State ARB:
  - Pick combinationally; awvalid_o=1 if any eligible; payload muxed from the winner.
  - Handshake (awvalid_o & awready_i): awready_o = one-hot winner; push_ID_o=1 with ID_o={bin,onehot}; rr_ptr <= (winner+1) wrap at N_TARG_PORT-1→0; stay in ARB. Zero-cycle latency.
  - Valid without ready: latch winner into lock_idx; go to HOLD.
- State HOLD:
  - Selection frozen on lock_idx; awvalid_o=1; payload stable (AXI rule).
  - Other ports' new requests are ignored.
  - On awready_i: accept, push, advance rr_ptr, return to ARB.
- Rules:
  - awready_o is never asserted without push_ID_o in the same cycle; exactly one push per AW beat.
  - This block is the FIFO's sole pusher, so grant_FIFO_ID_i cannot fall in HOLD. Simulation assertion flags a violation.
  - A locked requester dropping awvalid_i in HOLD is illegal (assertion); the block still holds its output.
  - N_TARG_PORT=1: rr_ptr stays 0; ID_o = {0, 1'b1}.
  - Reset mid-HOLD: aborts the request; no push emitted.

Optional Feature:
- AW_OUT_REG_EN defined:
  - Full-throughput two-entry spill register on the AW output path.
  - Arbitration handshake happens against the slice's ready; the push occurs at slice acceptance.
  - awvalid_o is delayed by 1 cycle. Payloads are emitted in push order.
  - Slice entries reset invalid.
- Undefined: direct combinational path as described above.

Decomposition:
- Package axi_node_pkg:
  - AW payload struct (id, addr, len, size, burst, user).
  - State enum {ARB, HOLD}.
  - Width helper constants.
- Sub-module axi_aw_rr_pick: combinational rotating-priority picker (req vector, ptr → one-hot grant, bin index, any).

Test Plan:
- Ports 2 and 5 valid, rr_ptr=0, awready_i=1 → port 2 granted, ID_o={3'd2,7'b0000100}, awid_o[6:4]=2; next cycle port 5, ID_o={3'd5,7'b0100000}.
- All 7 ports valid continuously, awready_i=1 → grants 0,1,…,6,0 in order; exactly 7 pushes in 7 cycles; wrap 6→0 verified.
- Port 3 valid, awready_i low 4 cycles, port 1 raises valid at cycle 2 → output stays port 3 with stable payload; single push when ready rises; port 1 served next.
- grant_FIFO_ID_i=0, port 0 valid → awvalid_o=0, no push, awready_o=0; grant returns → handshake in same cycle.
- Reset asserted while in HOLD → all outputs 0 immediately, rr_ptr=0, no push; after release, the request is re-arbitrated from port 0.
- With AW_OUT_REG_EN: back-to-back requests with awready_i=1 → one AW per cycle after 1-cycle latency; push order matches awid_o order.
